// File: rtl/imem_port_arbiter_if.sv
// Bundle of fetch, loader, boot-control and BRAM signals around the imem port arbiter.
// Latency: none, wiring only.
// Backpressure: none here; the arbiter's grant outputs carry it.
interface imem_port_arbiter_if #(
    parameter int AW = 10
);
    // fetch side
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_stall;
    logic          if_flush;
    logic          if_rvalid;
    logic [31:0]   if_rdata;

    // loader side
    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [31:0]   ld_rdata;

    // boot control
    logic          boot_hold;

    // BRAM port
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    // environment side: requesters and the BRAM itself
    modport master (
        output if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, boot_hold, mem_rdata,
        input  if_gnt, if_stall, if_flush, if_rvalid, if_rdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    // arbiter side
    modport slave (
        input  if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, boot_hold, mem_rdata,
        output if_gnt, if_stall, if_flush, if_rvalid, if_rdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-BRAM port between fetch (priority) and the boot/debug loader.
// Latency: grant is combinational in the request cycle; read data and rvalid follow one cycle later.
// Backpressure: a denied fetch gets if_stall; a denied loader waits at most STARVE_MAX cycles in RUN.
module imem_port_arbiter #(
    parameter int AW         = 10,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_port_arbiter_if.slave    bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RESUME = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_next;
    logic          flush_q;
    logic          if_rvalid_q;
    logic          ld_rvalid_q;

    logic          fetch_blocked;
    logic          if_gnt;
    logic          ld_gnt;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] if_word;

    // Only the word index of the fetch PC addresses the BRAM; byte offset and upper bits are ignored.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:AW+2], bus.if_addr[1:0]};
    assign if_word          = bus.if_addr[AW+1:2];

    // Next state, grants, starvation counter update and BRAM mux.
    always_comb begin
        state_next    = state;
        fetch_blocked = 1'b1;
        if_gnt        = 1'b0;
        ld_gnt        = 1'b0;
        starve_next   = starve_cnt;
        mem_addr      = '0;
        mem_wdata     = '0;

        case (state)
            BOOT:    if (!bus.boot_hold) state_next = RESUME;
            RESUME:  state_next = RUN;
            RUN:     if (bus.boot_hold) state_next = BOOT;
            default: state_next = BOOT;
        endcase

        // Fetch may only touch memory once the pipeline has been flushed and boot_hold is low.
        fetch_blocked = (state != RUN) || bus.boot_hold;

        if (fetch_blocked) begin
            ld_gnt = bus.ld_req;
        end else if (bus.if_req && bus.ld_req) begin
            // Fetch wins ties until the loader has waited STARVE_MAX cycles.
            ld_gnt = (starve_cnt == STARVE_LIM);
            if_gnt = !ld_gnt;
        end else begin
            if_gnt = bus.if_req;
            ld_gnt = bus.ld_req;
        end

        if (!bus.ld_req || ld_gnt) begin
            starve_next = '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_next = starve_cnt + 1'b1;
        end

        if (ld_gnt) begin
            mem_addr  = bus.ld_addr;
            mem_wdata = bus.ld_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_word;
        end

        mem_en = if_gnt | ld_gnt;
        mem_we = ld_gnt & bus.ld_we;
    end

    // State, starvation counter, flush pulse and response tags; reset drops in-flight responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            starve_cnt  <= '0;
            flush_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            ld_rvalid_q <= 1'b0;
        end else begin
            state       <= state_next;
            starve_cnt  <= starve_next;
            flush_q     <= (state_next == RESUME);
            if_rvalid_q <= if_gnt;
            ld_rvalid_q <= ld_gnt & ~bus.ld_we;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.if_stall  = bus.if_req & ~if_gnt;
    assign bus.if_flush  = flush_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.ld_gnt    = ld_gnt;
    assign bus.ld_rvalid = ld_rvalid_q;
    assign bus.ld_rdata  = bus.mem_rdata;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a one-cycle-latency BRAM model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 4 units later.
// Backpressure: fetch stall and loader starvation pattern are checked cycle by cycle.
module tb_imem_port_arbiter;
    localparam int AW         = 10;
    localparam int STARVE_MAX = 8;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    imem_port_arbiter_if #(.AW(AW)) bus ();

    imem_port_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // BRAM model: synchronous write, registered read
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] rdata_q;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            rdata_q <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rdata_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rdata_q = 32'h0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        mem[3] = 32'h12345678;

        reset         = 1'b0;
        bus.boot_hold = 1'b0;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h0;
        bus.ld_req    = 1'b0;
        bus.ld_we     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_wdata  = 32'h0;

        // during reset: BOOT rules on combinational outputs, registers cleared
        #2;
        check("rst_if_gnt",    32'(bus.if_gnt),    32'd0);
        check("rst_if_stall",  32'(bus.if_stall),  32'd1);
        check("rst_if_flush",  32'(bus.if_flush),  32'd0);
        check("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        check("rst_ld_rvalid", 32'(bus.ld_rvalid), 32'd0);
        check("rst_starve",    32'(dut.starve_cnt), 32'd0);

        // cycle 0: BOOT
        next_cycle();
        reset = 1'b1;
        #3;
        check("c0_if_gnt",   32'(bus.if_gnt),   32'd0);
        check("c0_if_stall", 32'(bus.if_stall), 32'd1);
        check("c0_if_flush", 32'(bus.if_flush), 32'd0);

        // cycle 1: RESUME, flush pulse
        next_cycle(); #3;
        check("c1_if_gnt",   32'(bus.if_gnt),   32'd0);
        check("c1_if_stall", 32'(bus.if_stall), 32'd1);
        check("c1_if_flush", 32'(bus.if_flush), 32'd1);

        // cycle 2: RUN, first fetch grant at word 0
        next_cycle(); #3;
        check("c2_if_gnt",   32'(bus.if_gnt),   32'd1);
        check("c2_if_stall", 32'(bus.if_stall), 32'd0);
        check("c2_if_flush", 32'(bus.if_flush), 32'd0);
        check("c2_mem_en",   32'(bus.mem_en),   32'd1);
        check("c2_mem_addr", 32'(bus.mem_addr), 32'd0);

        // boot_hold rises mid-RUN with fetch pending; loader writes DEADBEEF to word 5
        next_cycle();
        bus.boot_hold = 1'b1;
        bus.ld_req    = 1'b1;
        bus.ld_we     = 1'b1;
        bus.ld_addr   = 10'd5;
        bus.ld_wdata  = 32'hDEADBEEF;
        #3;
        check("hold_if_gnt",    32'(bus.if_gnt),    32'd0);
        check("hold_if_stall",  32'(bus.if_stall),  32'd1);
        check("hold_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("hold_ld_gnt",    32'(bus.ld_gnt),    32'd1);
        check("hold_mem_we",    32'(bus.mem_we),    32'd1);
        check("hold_mem_addr",  32'(bus.mem_addr),  32'd5);
        check("hold_mem_wdata", bus.mem_wdata,      32'hDEADBEEF);

        // BOOT: write produces no loader rvalid, fetch still frozen
        next_cycle();
        bus.ld_req = 1'b0;
        #3;
        check("wr_ld_rvalid",  32'(bus.ld_rvalid), 32'd0);
        check("wr_if_rvalid",  32'(bus.if_rvalid), 32'd0);
        check("boot_if_gnt",   32'(bus.if_gnt),    32'd0);
        check("boot_mem_en",   32'(bus.mem_en),    32'd0);

        // release boot_hold: BOOT this cycle, RESUME next
        next_cycle();
        bus.boot_hold = 1'b0;
        bus.if_addr   = 32'h14;
        #3;
        check("exit_boot_if_gnt", 32'(bus.if_gnt),   32'd0);
        check("exit_boot_flush",  32'(bus.if_flush), 32'd0);
        next_cycle(); #3;
        check("exit_resume_flush", 32'(bus.if_flush), 32'd1);
        check("exit_resume_gnt",   32'(bus.if_gnt),   32'd0);

        // RUN: fetch 0x14 reads word 5
        next_cycle(); #3;
        check("rd5_if_gnt",   32'(bus.if_gnt),   32'd1);
        check("rd5_mem_addr", 32'(bus.mem_addr), 32'd5);
        check("rd5_mem_we",   32'(bus.mem_we),   32'd0);
        next_cycle();
        bus.if_req = 1'b0;
        #3;
        check("rd5_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("rd5_if_rdata",  bus.if_rdata,       32'hDEADBEEF);

        // loader read of word 3 with no fetch
        next_cycle();
        bus.ld_req  = 1'b1;
        bus.ld_we   = 1'b0;
        bus.ld_addr = 10'd3;
        #3;
        check("ldrd_gnt",      32'(bus.ld_gnt),   32'd1);
        check("ldrd_mem_addr", 32'(bus.mem_addr), 32'd3);
        check("ldrd_mem_we",   32'(bus.mem_we),   32'd0);
        next_cycle();
        bus.ld_req = 1'b0;
        #3;
        check("ldrd_rvalid",    32'(bus.ld_rvalid), 32'd1);
        check("ldrd_rdata",     bus.ld_rdata,       32'h12345678);
        check("ldrd_if_rvalid", 32'(bus.if_rvalid), 32'd0);

        // both requesting continuously: loader wins every 9th cycle
        for (int k = 1; k <= 18; k++) begin
            next_cycle();
            bus.if_req = 1'b1;
            bus.ld_req = 1'b1;
            #3;
            check($sformatf("stv%0d_ld_gnt", k),   32'(bus.ld_gnt),     ((k % 9) == 0) ? 32'd1 : 32'd0);
            check($sformatf("stv%0d_if_gnt", k),   32'(bus.if_gnt),     ((k % 9) == 0) ? 32'd0 : 32'd1);
            check($sformatf("stv%0d_if_stall", k), 32'(bus.if_stall),   ((k % 9) == 0) ? 32'd1 : 32'd0);
            check($sformatf("stv%0d_cnt", k),      32'(dut.starve_cnt), 32'((k - 1) % 9));
            check($sformatf("stv%0d_ld_rvalid", k), 32'(bus.ld_rvalid),
                  (k > 1 && ((k - 1) % 9) == 0) ? 32'd1 : 32'd0);
        end

        // one more contended cycle so the counter is non-zero before reset
        next_cycle(); #3;
        check("pre_rst_if_gnt", 32'(bus.if_gnt), 32'd1);
        next_cycle(); #3;
        check("pre_rst_cnt",    32'(dut.starve_cnt), 32'd1);
        check("pre_rst_if_gnt2", 32'(bus.if_gnt),    32'd1);

        // reset pulse during a granted fetch
        bus.ld_req = 1'b0;
        reset      = 1'b0;
        #1;
        check("inrst_if_gnt",   32'(bus.if_gnt),     32'd0);
        check("inrst_if_stall", 32'(bus.if_stall),   32'd1);
        check("inrst_cnt",      32'(dut.starve_cnt), 32'd0);
        next_cycle(); #3;
        check("postrst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        check("postrst_ld_rvalid", 32'(bus.ld_rvalid), 32'd0);
        reset = 1'b1;
        #1;
        check("postrst_boot_gnt",   32'(bus.if_gnt),   32'd0);
        check("postrst_boot_flush", 32'(bus.if_flush), 32'd0);
        next_cycle(); #3;
        check("postrst_resume_flush", 32'(bus.if_flush), 32'd1);
        next_cycle(); #3;
        check("postrst_run_gnt", 32'(bus.if_gnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
